mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter BASE_ADDR, 32'h0000_0400, byte address of data-memory word 0.
REQ-002 Parameter MEM_WORDS, 1024, number of 32-bit words in the data RAM.
REQ-003 Parameter TIMEOUT, 16, maximum cycles RAM_Req is held without RAM_Ack.
REQ-004 Clk  in  1  single clock; all state updates on the rising edge.
REQ-005 Reset  in  1  synchronous, active-low reset, sampled on the rising edge of Clk.
REQ-006 Mem_Req  in  1  start one memory operation; sampled only in IDLE.
REQ-007 Mem_WrEn  in  1  1 = store, 0 = load.
REQ-008 ByteOp  in  1  1 = byte access (lb/sb), 0 = word access (lw/sw).
REQ-009 ALU_MEM_Addr  in  32  byte address (ALU result).
REQ-010 MEM_DataIn  in  32  store data (RF_B).
REQ-011 RAM_Req  out  1  RAM request, held until acknowledged.
REQ-012 RAM_We  out  1  RAM write enable, valid with RAM_Req.
REQ-013 RAM_Addr  out  clog2(MEM_WORDS)  RAM word index.
REQ-014 RAM_BE  out  4  byte enables; bit i = bits 8i+7:8i.
REQ-015 RAM_Wdata  out  32  RAM write data.
REQ-016 RAM_Ack  in  1  RAM completion; RAM_Rdata valid in the same cycle for reads.
REQ-017 RAM_Rdata  in  32  RAM read data.
REQ-018 MEM_DataOut  out  32  registered load result.
REQ-019 Busy  out  1  high in any state other than IDLE; the pipeline stalls on it.
REQ-020 Done  out  1  one-cycle completion pulse.
REQ-021 Mem_Err  out  1  error status, valid only while Done=1.

Function
REQ-022 The block SHALL implement states IDLE, ACCESS, DONE.
REQ-023 In IDLE with Mem_Req=1, the block SHALL latch the address, data, WrEn and ByteOp, and SHALL check them.
- Word access with Addr[1:0]!=0 is an error.
- Addr < BASE_ADDR or Addr >= BASE_ADDR+4*MEM_WORDS is an error.
- On error: next state DONE, Mem_Err=1, no RAM request issued.
- Otherwise: next state ACCESS.
REQ-024 The word index SHALL be (Addr-BASE_ADDR)>>2, computed with 32-bit unsigned arithmetic.
REQ-025 In ACCESS, RAM_Req SHALL be 1 and RAM_We/RAM_Addr/RAM_BE/RAM_Wdata SHALL be held stable until RAM_Ack=1.
REQ-026 Word store: RAM_BE=4'b1111 and RAM_Wdata=MEM_DataIn.
- Byte store: RAM_BE=1<<Addr[1:0] and RAM_Wdata={4{MEM_DataIn[7:0]}}.
- Loads: RAM_BE=4'b1111.
REQ-027 On RAM_Ack in ACCESS, the next state SHALL be DONE.
- Loads capture MEM_DataOut: the full word for a word load, or byte Addr[1:0] zero-extended to 32 bits for a byte load.
REQ-028 ACCESS SHALL count cycles from 1.
- If TIMEOUT cycles elapse without RAM_Ack, RAM_Req SHALL drop and the next state SHALL be DONE with Mem_Err=1.
- MEM_DataOut is unchanged on timeout.
REQ-029 RAM_Ack arriving in the same cycle the count reaches TIMEOUT SHALL count as success (no error).
REQ-030 DONE SHALL last exactly one cycle with Done=1, then return to IDLE.
- Mem_Req presented during DONE is ignored; it is sampled again in IDLE.
REQ-031 Mem_Req SHALL be ignored in ACCESS and DONE; RAM_Ack SHALL be ignored outside ACCESS.
REQ-032 Minimum latency: request in IDLE at cycle 0, RAM_Ack at cycle 1, Done=1 at cycle 2, IDLE at cycle 3.
REQ-033 On a store, MEM_DataOut SHALL keep its previous value.

Reset
REQ-034 While Reset=0 at a rising edge, the block SHALL enter IDLE and clear the timeout counter. Outputs:
- MEM_DataOut=0, RAM_Req=0, RAM_We=0, RAM_BE=0, RAM_Addr=0, RAM_Wdata=0.
- Busy=0, Done=0, Mem_Err=0.
REQ-035 Reset asserted in ACCESS SHALL abort the access.
- RAM_Req=0 from the next cycle; no Done pulse; a late RAM_Ack SHALL be ignored.

Verification
REQ-036 Word load: BASE_ADDR default, Addr=0x408, RAM_Ack after 3 cycles with Rdata=0xDEADBEEF.
- Expected: RAM_Addr=2, BE=1111, Done once, MEM_DataOut=0xDEADBEEF, Mem_Err=0.
REQ-037 Byte store: Addr=0x403, DataIn=0x12345678, immediate RAM_Ack.
- Expected: RAM_Addr=0, BE=1000, Wdata=0x78787878, We=1.
REQ-038 Byte load: Addr=0x401, Rdata=0xAABBCCDD.
- Expected: MEM_DataOut=0x000000CC.
REQ-039 Errors:
- Word load at Addr=0x402: Done with Mem_Err=1 one cycle after the request; RAM_Req never asserted.
- Addr=0x3FC or Addr=0x1400: same response.
REQ-040 Timeout: RAM_Ack held at 0.
- Expected: RAM_Req high for exactly 16 cycles, then Done with Mem_Err=1.
- Second run: RAM_Ack on cycle 16 gives Mem_Err=0.
REQ-041 Reset=0 on the 2nd ACCESS cycle.
- Expected: IDLE and all outputs 0 the next cycle, no Done pulse; a RAM_Ack one cycle later has no effect.

Source files
------------

// File: rtl/mem_stage_if.sv
// Bundle of pipeline-side and RAM-side signals for the memory-stage controller.
// The controller binds to the slave modport; the pipeline/RAM environment binds to master.
interface mem_stage_if #(
  parameter int MEM_WORDS = 1024
);
  localparam int AW = $clog2(MEM_WORDS);

  logic          mem_req;
  logic          mem_wr_en;
  logic          byte_op;
  logic [31:0]   alu_mem_addr;
  logic [31:0]   mem_data_in;

  logic          ram_req;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdata;
  logic          ram_ack;
  logic [31:0]   ram_rdata;

  logic [31:0]   mem_data_out;
  logic          busy;
  logic          done;
  logic          mem_err;

  modport slave (
    input  mem_req, mem_wr_en, byte_op, alu_mem_addr, mem_data_in,
    input  ram_ack, ram_rdata,
    output ram_req, ram_we, ram_addr, ram_be, ram_wdata,
    output mem_data_out, busy, done, mem_err
  );

  modport master (
    output mem_req, mem_wr_en, byte_op, alu_mem_addr, mem_data_in,
    output ram_ack, ram_rdata,
    input  ram_req, ram_we, ram_addr, ram_be, ram_wdata,
    input  mem_data_out, busy, done, mem_err
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: validates a load/store, drives one RAM request with a
// bounded wait, and returns a registered load result with a one-cycle Done pulse.
module mem_stage_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int          MEM_WORDS = 1024,
  parameter int          TIMEOUT   = 16
) (
  input  logic      clk,
  input  logic      reset,
  mem_stage_if.slave bus
);
  localparam int          AW    = $clog2(MEM_WORDS);
  localparam int          CW    = $clog2(TIMEOUT + 1);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * MEM_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_byte;
  logic [1:0]    byte_sel;
  logic          addr_bad;

  function automatic logic [3:0] lane_en(input logic wr, input logic bo, input logic [1:0] sel);
    if (wr && bo) return 4'b0001 << sel;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] store_data(input logic bo, input logic [31:0] d);
    return bo ? {4{d[7:0]}} : d;
  endfunction

  function automatic logic [31:0] load_data(input logic bo, input logic [1:0] sel,
                                            input logic [31:0] r);
    if (!bo) return r;
    case (sel)
      2'd0:    return {24'd0, r[7:0]};
      2'd1:    return {24'd0, r[15:8]};
      2'd2:    return {24'd0, r[23:16]};
      default: return {24'd0, r[31:24]};
    endcase
  endfunction

  // Misaligned word access or an address outside the RAM window is rejected up front.
  always_comb begin
    addr_bad = (!bus.byte_op && (bus.alu_mem_addr[1:0] != 2'b00)) ||
               ({1'b0, bus.alu_mem_addr} < {1'b0, BASE_ADDR}) ||
               ({1'b0, bus.alu_mem_addr} >= LIMIT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      cnt              <= '0;
      is_byte          <= 1'b0;
      byte_sel         <= 2'b00;
      bus.ram_req      <= 1'b0;
      bus.ram_we       <= 1'b0;
      bus.ram_addr     <= '0;
      bus.ram_be       <= 4'b0000;
      bus.ram_wdata    <= 32'd0;
      bus.mem_data_out <= 32'd0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.mem_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done    <= 1'b0;
          bus.mem_err <= 1'b0;
          if (bus.mem_req) begin
            bus.busy <= 1'b1;
            if (addr_bad) begin
              state       <= DONE;
              bus.done    <= 1'b1;
              bus.mem_err <= 1'b1;
            end else begin
              state         <= ACCESS;
              cnt           <= CW'(1);
              is_byte       <= bus.byte_op;
              byte_sel      <= bus.alu_mem_addr[1:0];
              bus.ram_req   <= 1'b1;
              bus.ram_we    <= bus.mem_wr_en;
              bus.ram_addr  <= AW'((bus.alu_mem_addr - BASE_ADDR) >> 2);
              bus.ram_be    <= lane_en(bus.mem_wr_en, bus.byte_op, bus.alu_mem_addr[1:0]);
              bus.ram_wdata <= store_data(bus.byte_op, bus.mem_data_in);
            end
          end
        end
        // An acknowledge on the final counted cycle still wins over the timeout.
        ACCESS: begin
          if (bus.ram_ack) begin
            state       <= DONE;
            bus.ram_req <= 1'b0;
            bus.done    <= 1'b1;
            bus.mem_err <= 1'b0;
            if (!bus.ram_we) bus.mem_data_out <= load_data(is_byte, byte_sel, bus.ram_rdata);
          end else if (cnt == CW'(TIMEOUT)) begin
            state       <= DONE;
            bus.ram_req <= 1'b0;
            bus.done    <= 1'b1;
            bus.mem_err <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state       <= IDLE;
          cnt         <= '0;
          bus.busy    <= 1'b0;
          bus.done    <= 1'b0;
          bus.mem_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized bench for mem_stage_ctrl against a per-transaction reference model.
module tb_mem_stage_ctrl;
  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam int          WORDS = 1024;
  localparam int          TMO   = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if #(.MEM_WORDS(WORDS)) bus ();

  mem_stage_ctrl #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_dout = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_req"},  32'(bus.ram_req), 32'd0);
    check({tag, "_dout"}, bus.mem_data_out, model_dout);
  endtask

  // ack_at: ACCESS cycle (1-based) on which RAM_Ack is raised; 0 or >TMO means never.
  task automatic run_txn(input bit wr, input bit bo, input logic [31:0] addr,
                         input logic [31:0] din, input logic [31:0] rdata,
                         input int ack_at, input bit req_in_done);
    bit          bad, ok, seen;
    logic [31:0] exp_idx, exp_wd, exp_ld;
    logic [3:0]  exp_be;
    int          exp_req, reqs;
    longint      a, lim;

    a   = longint'(addr);
    lim = longint'(BASE) + 4 * WORDS;
    bad = (!bo && (addr % 4 != 0)) || (a < longint'(BASE)) || (a >= lim);
    exp_idx = (addr - BASE) / 4;
    exp_be  = (wr && bo) ? 4'(1 << (addr % 4)) : 4'hF;
    exp_wd  = bo ? (din % 256) * 32'h0101_0101 : din;
    exp_ld  = bo ? ((rdata >> (8 * (addr % 4))) % 256) : rdata;
    ok      = !bad && ack_at >= 1 && ack_at <= TMO;
    exp_req = bad ? 0 : (ok ? ack_at : TMO);

    bus.mem_req      = 1'b1;
    bus.mem_wr_en    = wr;
    bus.byte_op      = bo;
    bus.alu_mem_addr = addr;
    bus.mem_data_in  = din;
    bus.ram_ack      = 1'($urandom_range(0, 1));
    reqs = 0;
    seen = 1'b0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      bus.mem_req      = 1'b0;
      bus.mem_wr_en    = 1'($urandom_range(0, 1));
      bus.byte_op      = 1'($urandom_range(0, 1));
      bus.alu_mem_addr = $urandom;
      bus.mem_data_in  = $urandom;
      bus.ram_ack      = 1'b0;
      bus.ram_rdata    = $urandom;
      if (bus.done) begin
        seen = 1'b1;
        if (ok && !wr) model_dout = exp_ld;
        check("done_cycle", 32'(cyc), 32'(exp_req + 1));
        check("req_cycles", 32'(reqs), 32'(exp_req));
        check("mem_err",    32'(bus.mem_err), 32'(!ok));
        check("dout",       bus.mem_data_out, model_dout);
        check("busy_done",  32'(bus.busy), 32'd1);
        check("req_done",   32'(bus.ram_req), 32'd0);
        if (req_in_done) begin
          bus.mem_req      = 1'b1;
          bus.byte_op      = 1'b0;
          bus.alu_mem_addr = BASE;
        end
      end else if (bus.ram_req) begin
        reqs++;
        check("ram_addr", 32'(bus.ram_addr), exp_idx);
        check("ram_be",   32'(bus.ram_be), 32'(exp_be));
        check("ram_we",   32'(bus.ram_we), 32'(wr));
        if (wr) check("ram_wdata", bus.ram_wdata, exp_wd);
        check("busy_acc", 32'(bus.busy), 32'd1);
        if (reqs == ack_at) begin
          bus.ram_ack   = 1'b1;
          bus.ram_rdata = rdata;
        end
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.mem_req = 1'b0;
    bus.ram_ack = 1'($urandom_range(0, 1));
    check_idle("after");
  endtask

  task automatic reset_abort();
    bus.mem_req      = 1'b1;
    bus.mem_wr_en    = 1'b0;
    bus.byte_op      = 1'b0;
    bus.alu_mem_addr = BASE + 32'h10;
    bus.ram_ack      = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.mem_req = 1'b0;
    check("abort_req1", 32'(bus.ram_req), 32'd1);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    model_dout = 32'd0;
    check("rst_req",   32'(bus.ram_req), 32'd0);
    check("rst_we",    32'(bus.ram_we), 32'd0);
    check("rst_be",    32'(bus.ram_be), 32'd0);
    check("rst_addr",  32'(bus.ram_addr), 32'd0);
    check("rst_wdata", bus.ram_wdata, 32'd0);
    check("rst_err",   32'(bus.mem_err), 32'd0);
    check_idle("rst");
    reset         = 1'b1;
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'hCAFE_F00D;
    @(posedge clk); @(negedge clk);
    bus.ram_ack = 1'b0;
    check_idle("late_ack");
    @(posedge clk); @(negedge clk);
    check_idle("late_ack2");
  endtask

  initial begin
    logic [31:0] addr;
    bus.mem_req      = 1'b0;
    bus.mem_wr_en    = 1'b0;
    bus.byte_op      = 1'b0;
    bus.alu_mem_addr = 32'd0;
    bus.mem_data_in  = 32'd0;
    bus.ram_ack      = 1'b0;
    bus.ram_rdata    = 32'd0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("init_req",   32'(bus.ram_req), 32'd0);
    check("init_be",    32'(bus.ram_be), 32'd0);
    check("init_wdata", bus.ram_wdata, 32'd0);
    check("init_err",   32'(bus.mem_err), 32'd0);
    check_idle("init");
    reset = 1'b1;
    @(negedge clk);

    run_txn(1'b0, 1'b0, 32'h408, 32'd0,         32'hDEAD_BEEF, 3,  1'b0);
    run_txn(1'b1, 1'b1, 32'h403, 32'h1234_5678, 32'd0,         1,  1'b0);
    run_txn(1'b0, 1'b1, 32'h401, 32'd0,         32'hAABB_CCDD, 2,  1'b1);
    run_txn(1'b0, 1'b0, 32'h402, 32'd0,         32'h1111_1111, 1,  1'b0);
    run_txn(1'b0, 1'b0, 32'h3FC, 32'd0,         32'h2222_2222, 1,  1'b0);
    run_txn(1'b1, 1'b0, 32'h1400, 32'h5555_AAAA, 32'd0,        1,  1'b0);
    run_txn(1'b0, 1'b0, 32'h13FC, 32'd0,        32'h0BAD_CAFE, 0,  1'b0);
    run_txn(1'b0, 1'b0, 32'h13FC, 32'd0,        32'h600D_CAFE, TMO, 1'b1);
    run_txn(1'b1, 1'b0, 32'h400, 32'h0F0F_0F0F, 32'd0,         TMO, 1'b0);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       addr = BASE + $urandom_range(0, 4 * WORDS - 1);
        1:       addr = BASE + 4 * WORDS - 4 + $urandom_range(0, 7);
        2:       addr = BASE - $urandom_range(1, 8);
        default: addr = $urandom;
      endcase
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, $urandom, $urandom,
              int'($urandom_range(0, TMO + 2)), 1'($urandom_range(0, 1)));
    end

    reset_abort();
    run_txn(1'b0, 1'b1, 32'h7FE, 32'd0, 32'h1357_9BDF, 4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
